n8_controller_responder: RTL and testbench
==========================================

// Module: n8_controller_responder
// PURPOSE
// - Controller-side end of the N8 serial pad protocol; emulates an N8 pad for the console-side n8_driver.
// - Captures 8 button levels on latch; shifts one bit per pulse rising edge onto data_out.
// - Used on the V_GPIO[28:26] header as an FPGA-hosted virtual pad, and in benches as the n8_driver's partner.
// - latch and pulse come from off-chip: both are async to clk and are synchronized internally.
// PARAMETERS
// - ACTIVE_LOW    1   1: pressed button drives 0 on data_out; 0: pressed drives 1
// - FILL_PRESSED  0   level after bit 7 is shifted out. 0: released level; 1: pressed level
// - TURBO_PERIOD  4   latch frames per turbo phase; only meaningful with N8_TURBO_EN; must be >= 1
// PORTS
// - clk         in   1  system clock (CLOCK_50 at top)
// - reset_n     in   1  asynchronous active-low reset
// - buttons     in   8  n8_buttons_t {a,b,select,start,up,down,left,right}; 1 = pressed; synchronous to clk
// - latch       in   1  from console side, async; rising edge captures buttons
// - pulse       in   1  from console side, async; rising edge advances one bit
// - data_out    out  1  serial button data, registered
// - busy        out  1  high in LATCHED or SHIFT
// - frame_done  out  1  one-clk pulse when the 8th pulse edge completes a frame
// - pulse_err   out  1  sticky flag: pulse edge seen while latch high; cleared by reset only
// - turbo_en    in   2  [0]=A turbo, [1]=B turbo; present only with N8_TURBO_EN
// BEHAVIOUR
// - Sync: latch and pulse each pass 2 FFs, then an edge register. rise = s & ~s_d.
// - Edge timing: a pin rising edge is detected 3 clk after it, and data_out updates 1 clk later (4 clk total).
// - State machine states: IDLE, LATCHED, SHIFT, DONE.
// - Shift register order: bit0 = A, bit1 = B, bit2 = Select, bit3 = Start, bit4 = Up, bit5 = Down, bit6 = Left, bit7 = Right.
// - Reset (async, reset_n = 0):
//     state = IDLE; shift register = all released; bit_cnt = 0;
//     data_out = released level (ACTIVE_LOW ? 1 : 0); busy = 0; frame_done = 0; pulse_err = 0; sync FFs = 0.
// - latch_rise, any state:
//     load the shift register from buttons (after turbo masking); bit_cnt = 0; state -> LATCHED;
//     data_out = A level. This is a mid-frame restart if SHIFT was active; no frame_done.
// - LATCHED: pulse_rise is ignored for shifting and sets pulse_err. latch_fall -> SHIFT.
// - SHIFT, on each pulse_rise:
//     shift right; bit_cnt += 1; data_out = next bit.
//     On the edge where bit_cnt reaches 8: data_out = FILL level; frame_done = 1 for 1 clk; state -> DONE.
// - DONE: pulse_rise is ignored and data_out holds FILL. latch_rise restarts the frame.
// - latch_rise and pulse_rise in the same clk: latch wins and the pulse is dropped. pulse_err is set only if latch was already high.
// - IDLE: data_out = released level. pulse_rise is ignored. busy = 0.
// - Button polarity: pressed level = ~ACTIVE_LOW. bit_cnt is 4 bits and saturates at 8 (never wraps).
// - buttons is sampled only in the clk of latch_rise. Changes during a frame are not visible until the next latch.
// CONFIGURATION
// - Macro N8_TURBO_EN, defined:
//     adds the turbo_en port, a TURBO_PERIOD frame counter and a phase bit.
//     The frame counter increments on each latch_rise; the phase toggles when it wraps at TURBO_PERIOD-1.
//     A (B) is reported pressed only if buttons.a (buttons.b) = 1, turbo_en[0] ([1]) = 1 and phase = 1.
//     With a turbo_en bit = 0, that button passes straight through.
//     Counter and phase reset to 0.
// - Macro N8_TURBO_EN, undefined: no turbo_en port and no counter; buttons load directly.
// STRUCTURE
// - Package n8_pkg:
//     n8_buttons_t packed struct;
//     N8_BIT_A..N8_BIT_RIGHT index constants;
//     N8_NUM_BITS = 8;
//     state enum n8_resp_state_e.
// - Sub-module n8_sync_edge: 2-FF synchronizer plus edge register; outputs level, rise and fall.
//     Instantiated once for latch and once for pulse.
// - Top holds the FSM, shift register, bit counter, flags and the optional turbo logic.
// TESTING
// - Frame read, ACTIVE_LOW = 1:
//     buttons = {a=1, start=1, others 0}; latch pulse; 7 pulses.
//     data_out sequence per bit = 0,1,1,0,1,1,1,1; after the 8th pulse data_out = 1 and frame_done is high for 1 clk.
// - Pulse during latch:
//     with latch high, raise pulse.
//     No shift (data_out stays A), pulse_err = 1 and remains 1 after further frames.
// - Mid-frame restart:
//     after 3 pulses, change buttons to right = 1 and latch again.
//     bit_cnt = 0, data_out = released, bit7 reads pressed, no frame_done from the aborted frame.
// - Simultaneous latch and pulse rise in one clk:
//     state -> LATCHED, data_out = A level, bit_cnt = 0.
// - Reset mid-SHIFT:
//     assert reset_n = 0 async between clk edges.
//     data_out = 1, busy = 0 and pulse_err = 0 immediately; a 9th pulse in DONE leaves data_out at FILL.
// - N8_TURBO_EN, TURBO_PERIOD = 2, a = 1, turbo_en = 2'b01:
//     bit0 over frames 0..7 = released,released,pressed,pressed,released,released,pressed,pressed.

Source files
------------

// File: rtl/n8_pkg.sv
// ----------------------------------------------------------------------------
// n8_pkg
// Shared types and constants for the N8 pad responder.
//   n8_buttons_t     : button levels {a,b,select,start,up,down,left,right},
//                      1 = pressed (a is the MSB of the packed vector)
//   N8_BIT_*         : position of each button in the serial shift order
//   N8_NUM_BITS      : bits per frame
//   n8_resp_state_e  : responder state machine encoding
//   n8_shift_order() : maps the button struct into serial shift order
// ----------------------------------------------------------------------------
package n8_pkg;

   typedef struct packed {
      logic a;
      logic b;
      logic select;
      logic start;
      logic up;
      logic down;
      logic left;
      logic right;
   } n8_buttons_t;

   localparam int N8_BIT_A      = 0;
   localparam int N8_BIT_B      = 1;
   localparam int N8_BIT_SELECT = 2;
   localparam int N8_BIT_START  = 3;
   localparam int N8_BIT_UP     = 4;
   localparam int N8_BIT_DOWN   = 5;
   localparam int N8_BIT_LEFT   = 6;
   localparam int N8_BIT_RIGHT  = 7;
   localparam int N8_NUM_BITS   = 8;

   typedef enum logic [1:0] {
      N8_IDLE    = 2'd0,
      N8_LATCHED = 2'd1,
      N8_SHIFT   = 2'd2,
      N8_DONE    = 2'd3
   } n8_resp_state_e;

   // Bit 0 of the result is the first bit presented on the wire (A).
   function automatic logic [N8_NUM_BITS-1:0] n8_shift_order(input n8_buttons_t btn);
      logic [N8_NUM_BITS-1:0] v;
      v                = '0;
      v[N8_BIT_A]      = btn.a;
      v[N8_BIT_B]      = btn.b;
      v[N8_BIT_SELECT] = btn.select;
      v[N8_BIT_START]  = btn.start;
      v[N8_BIT_UP]     = btn.up;
      v[N8_BIT_DOWN]   = btn.down;
      v[N8_BIT_LEFT]   = btn.left;
      v[N8_BIT_RIGHT]  = btn.right;
      return v;
   endfunction

endpackage

// File: rtl/n8_sync_edge.sv
// ----------------------------------------------------------------------------
// n8_sync_edge
// Brings an asynchronous pin into the clk domain and flags its edges.
// Two synchronizer flops, then a level register and its delayed copy; the
// edge flags compare those last two, so an edge is reported 3 clk after the
// pin moves.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset (all flops clear to 0)
//   pin_i   : asynchronous input
//   lvl_o   : synchronized level
//   rise_o  : one-clk pulse on a 0->1 transition
//   fall_o  : one-clk pulse on a 1->0 transition
// ----------------------------------------------------------------------------
module n8_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic lvl_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         lvl_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= pin_i;
         sync_q <= meta_q;
         lvl_q  <= sync_q;
         prev_q <= lvl_q;
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = lvl_q & ~prev_q;
   assign fall_o = ~lvl_q & prev_q;

endmodule

// File: rtl/n8_controller_responder.sv
// ----------------------------------------------------------------------------
// n8_controller_responder
// Controller-side end of the N8 serial pad protocol: emulates a pad for the
// console-side driver. A latch rising edge captures the 8 button levels; each
// pulse rising edge afterwards presents the next bit on data_out_o.
//
// Parameters
//   ACTIVE_LOW    1: pressed button drives 0 on the wire; 0: pressed drives 1
//   FILL_PRESSED  level shown after bit 7: 0 released, 1 pressed
//   TURBO_PERIOD  latch frames per turbo phase (>= 1), turbo build only
//
// Ports
//   clk_i         system clock
//   reset_n_i     asynchronous active-low reset
//   buttons_i     n8_buttons_t, 1 = pressed, synchronous to clk_i
//   latch_i       asynchronous, rising edge captures buttons_i
//   pulse_i       asynchronous, rising edge advances one bit
//   data_out_o    serial button data (registered)
//   busy_o        high while LATCHED or SHIFT
//   frame_done_o  one-clk pulse when the 8th pulse edge completes a frame
//   pulse_err_o   sticky: pulse edge seen while latch was already high
//   turbo_en_i    [0] A turbo, [1] B turbo (only when N8_TURBO_EN is defined)
//
// Build option: define N8_TURBO_EN to add turbo_en_i and the turbo frame
// counter. Without it, buttons load straight into the shift register.
// ----------------------------------------------------------------------------
module n8_controller_responder
   import n8_pkg::*;
#(
   parameter int ACTIVE_LOW   = 1,
   parameter int FILL_PRESSED = 0,
   parameter int TURBO_PERIOD = 4
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  n8_buttons_t buttons_i,
   input  logic        latch_i,
   input  logic        pulse_i,
`ifdef N8_TURBO_EN
   input  logic [1:0]  turbo_en_i,
`endif
   output logic        data_out_o,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        pulse_err_o
);

   localparam logic LVL_RELEASED = (ACTIVE_LOW != 0);
   localparam logic LVL_PRESSED  = ~LVL_RELEASED;
   localparam logic FILL_BIT     = (FILL_PRESSED != 0);

   // Shift register holds logical "pressed" bits; polarity is applied only
   // when a bit is driven onto the wire.
   function automatic logic wire_level(input logic pressed);
      return pressed ? LVL_PRESSED : LVL_RELEASED;
   endfunction

   logic latch_lvl, latch_rise, latch_fall;
   logic pulse_lvl, pulse_rise, pulse_fall;
   logic unused_pulse;

   n8_sync_edge u_latch_sync (
      .clk_i  (clk_i),
      .rst_ni (reset_n_i),
      .pin_i  (latch_i),
      .lvl_o  (latch_lvl),
      .rise_o (latch_rise),
      .fall_o (latch_fall)
   );

   n8_sync_edge u_pulse_sync (
      .clk_i  (clk_i),
      .rst_ni (reset_n_i),
      .pin_i  (pulse_i),
      .lvl_o  (pulse_lvl),
      .rise_o (pulse_rise),
      .fall_o (pulse_fall)
   );

   // Only the rising edge of pulse matters to the protocol.
   assign unused_pulse = pulse_lvl ^ pulse_fall;

   n8_buttons_t masked_btn;

`ifdef N8_TURBO_EN
   localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          phase_q, phase_d;

   // The mask uses the phase in force before this latch advances the counter,
   // so the first TURBO_PERIOD frames after reset report A/B released.
   always_comb begin
      masked_btn = buttons_i;
      tcnt_d     = tcnt_q;
      phase_d    = phase_q;
      if (turbo_en_i[0]) masked_btn.a = buttons_i.a & phase_q;
      if (turbo_en_i[1]) masked_btn.b = buttons_i.b & phase_q;
      if (latch_rise) begin
         if (tcnt_q == TW'(TURBO_PERIOD - 1)) begin
            tcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            tcnt_d = tcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         tcnt_q  <= tcnt_d;
         phase_q <= phase_d;
      end
   end
`else
   always_comb masked_btn = buttons_i;
`endif

   n8_resp_state_e         state_q, state_d;
   logic [N8_NUM_BITS-1:0] shift_q, shift_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   data_q, data_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;

      // A pulse arriving together with the latch edge is not an error: the
      // latch was not yet high from the pad's point of view.
      if (pulse_rise && latch_lvl && !latch_rise) err_d = 1'b1;

      if (latch_rise) begin
         // Latch wins over everything, including a frame in progress.
         shift_d = n8_shift_order(masked_btn);
         cnt_d   = '0;
         state_d = N8_LATCHED;
         data_d  = wire_level(shift_d[N8_BIT_A]);
      end else begin
         unique case (state_q)
            N8_LATCHED: begin
               if (latch_fall) state_d = N8_SHIFT;
            end
            N8_SHIFT: begin
               if (pulse_rise) begin
                  // FILL_BIT enters from the top, so after 8 shifts bit 0
                  // already carries the fill level.
                  shift_d = {FILL_BIT, shift_q[N8_NUM_BITS-1:1]};
                  cnt_d   = (cnt_q == 4'(N8_NUM_BITS)) ? cnt_q : cnt_q + 4'd1;
                  data_d  = wire_level(shift_d[0]);
                  if (cnt_d == 4'(N8_NUM_BITS)) begin
                     done_d  = 1'b1;
                     state_d = N8_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= N8_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= LVL_RELEASED;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign data_out_o   = data_q;
   assign busy_o       = (state_q == N8_LATCHED) || (state_q == N8_SHIFT);
   assign frame_done_o = done_q;
   assign pulse_err_o  = err_q;

endmodule

// File: tb/tb_n8_controller_responder.sv
module tb_n8_controller_responder;
   import n8_pkg::*;

   localparam int TP = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        latch = 1'b0;
   logic        pulse = 1'b0;
   logic [7:0]  btn = 8'h00;
   logic [1:0]  turbo_en = 2'b00;
   n8_buttons_t btn_s;
   logic        data_out, busy, frame_done, pulse_err;

   assign btn_s = btn;

   always #5 clk = ~clk;

   n8_controller_responder #(
      .ACTIVE_LOW   (1),
      .FILL_PRESSED (0),
      .TURBO_PERIOD (TP)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .buttons_i    (btn_s),
      .latch_i      (latch),
      .pulse_i      (pulse),
`ifdef N8_TURBO_EN
      .turbo_en_i   (turbo_en),
`endif
      .data_out_o   (data_out),
      .busy_o       (busy),
      .frame_done_o (frame_done),
      .pulse_err_o  (pulse_err)
   );

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural pad model: the frame is a list of pressed flags in wire
   // order and a read position; the wire shows the flag at that position.
   logic [7:0] m_pressed;
   bit         m_loaded;
   int         m_pos;
   bit         m_latch;
   bit         m_err;
   int         m_done;
   int         m_frames;

   task automatic m_reset();
      m_pressed = '0; m_loaded = 0; m_pos = 0; m_latch = 0; m_err = 0; m_frames = 0;
   endtask

   task automatic m_latch_rise(input logic [7:0] b);
      for (int i = 0; i < 8; i++) m_pressed[i] = b[7-i];
`ifdef N8_TURBO_EN
      if (turbo_en[0] && ((m_frames / TP) % 2 == 0)) m_pressed[0] = 1'b0;
      if (turbo_en[1] && ((m_frames / TP) % 2 == 0)) m_pressed[1] = 1'b0;
`endif
      m_frames++;
      m_loaded = 1; m_pos = 0; m_latch = 1;
   endtask

   task automatic m_pulse_rise();
      if (m_latch) m_err = 1;
      else if (m_loaded && m_pos < 8) begin
         m_pos++;
         if (m_pos == 8) m_done++;
      end
   endtask

   function automatic logic exp_data();
      if (!m_loaded || m_pos >= 8) return 1'b1;
      return ~m_pressed[m_pos];
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".data"}, data_out, exp_data());
      check({tag, ".busy"}, busy, (m_loaded && m_pos < 8));
      check({tag, ".err"}, pulse_err, m_err);
      check({tag, ".done"}, done_cnt, m_done);
   endtask

   task automatic do_latch(input logic [7:0] b);
      btn = b; latch = 1'b1; m_latch_rise(b); step(6);
   endtask

   task automatic do_unlatch();
      latch = 1'b0; m_latch = 0; step(6);
   endtask

   task automatic do_pulse();
      pulse = 1'b1; m_pulse_rise(); step(6);
      pulse = 1'b0; step(6);
   endtask

   task automatic do_reset();
      @(negedge clk); reset_n = 1'b0; step(2);
      m_reset();
      reset_n = 1'b1; step(2);
   endtask

   typedef struct {
      logic [7:0] btn;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[5];

   int d0;

   initial begin
      // buttons {a,b,sel,start,up,down,left,right}; exp bit k = wire level of bit k
      tbl[0] = '{btn: 8'b1001_0000, exp: 8'b1111_0110};
      tbl[1] = '{btn: 8'h00,        exp: 8'hFF};
      tbl[2] = '{btn: 8'hFF,        exp: 8'h00};
      tbl[3] = '{btn: 8'b0000_0001, exp: 8'b0111_1111};
      tbl[4] = '{btn: 8'b0101_0101, exp: 8'b0101_0101};

      m_reset();
      m_done = 0;
      step(3);
      check("reset.data", data_out, 1'b1);
      check("reset.busy", busy, 1'b0);
      check("reset.frame_done", frame_done, 1'b0);
      check("reset.err", pulse_err, 1'b0);
      reset_n = 1'b1;
      step(2);

`ifdef N8_TURBO_EN
      begin
         logic [7:0] texp;
         texp = 8'b0011_0011; // frame f -> bit f, 1 = released on the wire
         turbo_en = 2'b01;
         for (int f = 0; f < 8; f++) begin
            do_latch(8'h80);
            check($sformatf("turbo.f%0d", f), data_out, texp[f]);
            do_unlatch();
         end
         turbo_en = 2'b00;
         do_reset();
      end
`endif

      // Edge-to-output latency: 4 clk from the latch pin rising.
      btn = 8'h80; latch = 1'b1; m_latch_rise(8'h80);
      repeat (3) @(posedge clk);
      #1 check("latency.3clk", data_out, 1'b1);
      @(posedge clk);
      #1 check("latency.4clk", data_out, 1'b0);
      step(3);
      do_unlatch();
      do_pulse();
      check_model("pre_sim");

      // Latch and pulse rising in the same clk while shifting.
      @(negedge clk);
      btn = 8'b0100_0000; latch = 1'b1; pulse = 1'b1; m_latch_rise(8'b0100_0000);
      step(6);
      check("sim.data", data_out, 1'b1);
      check("sim.err", pulse_err, 1'b0);
      check("sim.busy", busy, 1'b1);
      latch = 1'b0; pulse = 1'b0; m_latch = 0; step(6);
      for (int k = 1; k < 8; k++) begin
         do_pulse();
         check_model($sformatf("sim.p%0d", k));
      end
      do_pulse();
      check_model("sim.end");

      // Table-driven complete frames.
      for (int t = 0; t < 5; t++) begin
         do_latch(tbl[t].btn);
         check($sformatf("tbl%0d.b0", t), data_out, tbl[t].exp[0]);
         do_unlatch();
         for (int k = 1; k < 8; k++) begin
            do_pulse();
            check($sformatf("tbl%0d.b%0d", t, k), data_out, tbl[t].exp[k]);
         end
         d0 = done_cnt;
         do_pulse();
         check($sformatf("tbl%0d.fill", t), data_out, 1'b1);
         check($sformatf("tbl%0d.done", t), done_cnt, d0 + 1);
         check($sformatf("tbl%0d.busy", t), busy, 1'b0);
         do_pulse();
         check($sformatf("tbl%0d.p9", t), data_out, 1'b1);
         check($sformatf("tbl%0d.p9done", t), done_cnt, d0 + 1);
      end

      // Pulse while latch is high.
      do_latch(8'h80);
      pulse = 1'b1; m_pulse_rise(); step(6);
      check("perr.data", data_out, 1'b0);
      check("perr.err", pulse_err, 1'b1);
      pulse = 1'b0; step(6);
      do_unlatch();
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 8; k++) do_pulse();
         check_model($sformatf("perr.f%0d", f));
         do_latch(8'h00);
         do_unlatch();
      end
      check("perr.sticky", pulse_err, 1'b1);

      // Mid-frame restart.
      do_latch(8'b1001_0000);
      do_unlatch();
      for (int k = 0; k < 3; k++) do_pulse();
      d0 = done_cnt;
      do_latch(8'b0000_0001);
      check("restart.data", data_out, 1'b1);
      check("restart.busy", busy, 1'b1);
      do_unlatch();
      for (int k = 1; k < 8; k++) do_pulse();
      check("restart.bit7", data_out, 1'b0);
      check("restart.nodone", done_cnt, d0);
      do_pulse();
      check("restart.done", done_cnt, d0 + 1);

      // Asynchronous reset in the middle of a frame.
      do_latch(8'hA5);
      do_unlatch();
      for (int k = 0; k < 3; k++) do_pulse();
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("areset.data", data_out, 1'b1);
      check("areset.busy", busy, 1'b0);
      check("areset.err", pulse_err, 1'b0);
      m_reset();
      @(negedge clk); reset_n = 1'b1; step(2);
      do_pulse();
      check_model("areset.idle_pulse");

      // Randomized operation mix against the model.
      for (int it = 0; it < 80; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 1) begin
            if (latch) do_unlatch();
            do_latch(8'($urandom));
         end else if (r == 2) begin
            if (latch) do_unlatch();
         end else if (r <= 7) begin
            do_pulse();
         end else if (r == 8) begin
            btn = 8'($urandom); step(2);
         end else begin
            if (!latch) begin
               do_latch(8'($urandom));
               do_unlatch();
            end
         end
         check_model($sformatf("rnd%0d", it));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
